sparse_idx_gen: RTL and testbench

//  Converts a sparsity bitmap (1 = non-zero operand) into a stream of absolute bit indices, LANES per beat.

---
 rtl/sparse_idx_gen_pkg.sv | 26 ++
 rtl/sparse_idx_gen_lsb_pos_enc.sv | 30 +++
 rtl/sparse_idx_gen.sv | 168 ++++++++++++++++
 tb/tb_sparse_idx_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_idx_gen_pkg.sv
// Shared definitions for the sparse index generator: default sizes,
// the two-state FSM encoding and a constant log2 helper for sizing.
package sparse_idx_gen_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LANES      = 2;
    localparam int DEF_BASE_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Smallest n such that 2**n >= value; used to size index fields.
    function automatic int c_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sparse_idx_gen_lsb_pos_enc.sv
// Lowest-set-bit finder: isolates the least significant set bit of a
// bitmap as a one-hot word and also reports its binary position.
// Purely combinational; chained once per output lane in the top level.
module sparse_idx_gen_lsb_pos_enc
    import sparse_idx_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = c_log2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]  vec,
    output logic [DATA_WIDTH-1:0]  onehot,
    output logic [INDEX_WIDTH-1:0] pos,
    output logic                   found
);

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    assign onehot = vec & (~vec + DATA_WIDTH'(1));
    assign found  = |vec;

    // Binary-encode the one-hot word by OR-ing in the index of the hot bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (onehot[i]) begin
                pos = pos | INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/sparse_idx_gen.sv
// Sparse index generator: accepts a sparsity bitmap plus a row base and
// streams the absolute positions of its set bits, LANES per beat, with
// an explicit last flag. An all-zero bitmap still produces one empty
// terminating beat. Bits are cleared in place as they are emitted, so
// positions stay absolute without any running offset.
module sparse_idx_gen
    import sparse_idx_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = c_log2(DATA_WIDTH),
    parameter int LANES       = DEF_LANES,
    parameter int BASE_WIDTH  = DEF_BASE_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_seq,
    input  logic [BASE_WIDTH-1:0]             in_base,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*(BASE_WIDTH+1)-1:0]   out_idx,
    output logic [LANES-1:0]                  out_lane_vld,
    output logic                              out_last,
    output logic [INDEX_WIDTH:0]              out_count
);

    localparam int LANE_W = BASE_WIDTH + 1;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   seq_reg;
    logic [BASE_WIDTH-1:0]   base_reg;
    logic [INDEX_WIDTH:0]    count_reg;
    logic [INDEX_WIDTH:0]    in_popcount;
    logic [DATA_WIDTH-1:0]   residue;
    logic [LANES-1:0]        lane_found;
    logic [LANE_W-1:0]       lane_sum [LANES];
    logic                    last_beat;
    logic                    accept_in;
    logic                    accept_out;

    // Popcount of the incoming bitmap as a balanced adder tree: level 0
    // holds one bit per leaf, each following level halves the node count.
    for (genvar l = 0; l <= INDEX_WIDTH; l++) begin : g_lvl
        logic [INDEX_WIDTH:0] sums [DATA_WIDTH >> l];
        for (genvar j = 0; j < (DATA_WIDTH >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign sums[j] = {{INDEX_WIDTH{1'b0}}, in_seq[j]};
            end else begin : g_add
                assign sums[j] = g_lvl[l-1].sums[2*j] + g_lvl[l-1].sums[2*j+1];
            end
        end
    end

    assign in_popcount = g_lvl[INDEX_WIDTH].sums[0];

    // Lane chain: each stage finds the lowest bit still set after the
    // previous stages removed theirs, so lane k is the k-th lowest bit.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0]  remain_in;
        logic [DATA_WIDTH-1:0]  remain_out;
        logic [DATA_WIDTH-1:0]  hot;
        logic [INDEX_WIDTH-1:0] bit_pos;
        logic                   hit;

        if (k == 0) begin : g_first
            assign remain_in = seq_reg;
        end else begin : g_next
            assign remain_in = g_lane[k-1].remain_out;
        end

        sparse_idx_gen_lsb_pos_enc #(
            .DATA_WIDTH  (DATA_WIDTH),
            .INDEX_WIDTH (INDEX_WIDTH)
        ) u_enc (
            .vec    (remain_in),
            .onehot (hot),
            .pos    (bit_pos),
            .found  (hit)
        );

        assign remain_out    = remain_in & ~hot;
        assign lane_found[k] = hit;
        assign lane_sum[k]   = {1'b0, base_reg} + LANE_W'(bit_pos);
    end

    // Whatever survives the chain is what the next beat must still emit;
    // nothing left means the current beat closes the row.
    assign residue    = g_lane[LANES-1].remain_out;
    assign last_beat  = (residue == '0);
    assign accept_in  = (state == IDLE) && in_valid;
    assign accept_out = (state == EMIT) && out_ready;

    // State register, cleared asynchronously so a row in flight is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: flush wins over both handshakes; a row leaves EMIT only
    // when its last beat is taken.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_next = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready && last_beat) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Row datapath: latch bitmap/base/popcount on accept, strip emitted
    // bits after every taken beat, hold everything under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_reg   <= '0;
            base_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            seq_reg   <= '0;
            base_reg  <= '0;
            count_reg <= '0;
        end else if (accept_in) begin
            seq_reg   <= in_seq;
            base_reg  <= in_base;
            count_reg <= in_popcount;
        end else if (accept_out) begin
            seq_reg   <= residue;
        end
    end

    // Outputs decoded from state; unused lanes and idle cycles read as zero.
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == EMIT);
        out_last     = (state == EMIT) && last_beat;
        out_lane_vld = '0;
        out_idx      = '0;
        out_count    = count_reg;
        if (state == EMIT) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_found[k]) begin
                    out_lane_vld[k]               = 1'b1;
                    out_idx[k*LANE_W +: LANE_W]   = lane_sum[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_idx_gen.sv
// Self-checking bench for sparse_idx_gen: a table of hand-derived rows,
// hand sequences for flush / reset / back-to-back corner cases, and
// randomized rows checked beat by beat against a list-based model.
module tb_sparse_idx_gen;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int LN = 2;
    localparam int BW = 8;
    localparam int LW = BW + 1;
    localparam int OW = LN * LW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_seq;
    logic [BW-1:0] in_base;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_idx;
    logic [LN-1:0] out_lane_vld;
    logic          out_last;
    logic [IW:0]   out_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] seq;
        logic [BW-1:0] base;
        int            stall;
        int            exp_beats;
        logic [IW:0]   exp_count;
        logic [OW-1:0] exp_first;
        logic [OW-1:0] exp_last;
    } vec_t;

    vec_t table_q [6];

    sparse_idx_gen #(
        .DATA_WIDTH  (DW),
        .INDEX_WIDTH (IW),
        .LANES       (LN),
        .BASE_WIDTH  (BW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_seq       (in_seq),
        .in_base      (in_base),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_lane_vld (out_lane_vld),
        .out_last     (out_last),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Run one row through the DUT. The model lists the set-bit positions
    // of the bitmap and slices that list into LANES-wide beats.
    task automatic apply_stimulus(input logic [DW-1:0] seq, input logic [BW-1:0] base,
                                  input int stall, output int beats_seen,
                                  output logic [OW-1:0] first_idx,
                                  output logic [OW-1:0] last_idx,
                                  output int wait_cycles);
        int            pos_q[$];
        logic [OW-1:0] exp_idx[$];
        logic [LN-1:0] exp_vld[$];
        int            n_beats;
        int            n_stall;
        logic [OW-1:0] idx;
        logic [LN-1:0] vld;
        logic [LW-1:0] v;

        for (int i = 0; i < DW; i++) begin
            if (seq[i]) pos_q.push_back(i);
        end
        n_beats = (pos_q.size() == 0) ? 1 : (pos_q.size() + LN - 1) / LN;
        for (int b = 0; b < n_beats; b++) begin
            idx = '0;
            vld = '0;
            for (int k = 0; k < LN; k++) begin
                if (b * LN + k < pos_q.size()) begin
                    v = LW'(base) + LW'(pos_q[b * LN + k]);
                    idx[k*LW +: LW] = v;
                    vld[k] = 1'b1;
                end
            end
            exp_idx.push_back(idx);
            exp_vld.push_back(vld);
        end

        beats_seen  = 0;
        first_idx   = '0;
        last_idx    = '0;
        wait_cycles = 0;
        while (in_ready !== 1'b1 && wait_cycles < 50) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        if (in_ready !== 1'b1) begin
            check_output("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end

        in_valid = 1'b1;
        in_seq   = seq;
        in_base  = base;
        @(posedge clk); #1;

        for (int b = 0; b < n_beats; b++) begin
            n_stall  = (stall < 0) ? $urandom_range(0, 2) : stall;
            in_valid = 1'b1;
            in_seq   = $urandom;
            in_base  = BW'($urandom);
            for (int s = 0; s < n_stall; s++) begin
                out_ready = 1'b0;
                check_output("stall_valid", 64'(out_valid), 64'd1);
                check_output("stall_idx", 64'(out_idx), 64'(exp_idx[b]));
                check_output("stall_vld", 64'(out_lane_vld), 64'(exp_vld[b]));
                check_output("stall_last", 64'(out_last), 64'(b == n_beats - 1));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            check_output("beat_valid", 64'(out_valid), 64'd1);
            check_output("beat_in_ready", 64'(in_ready), 64'd0);
            check_output("beat_idx", 64'(out_idx), 64'(exp_idx[b]));
            check_output("beat_vld", 64'(out_lane_vld), 64'(exp_vld[b]));
            check_output("beat_last", 64'(out_last), 64'(b == n_beats - 1));
            check_output("beat_count", 64'(out_count), 64'(pos_q.size()));
            if (b == 0) first_idx = out_idx;
            last_idx = out_idx;
            beats_seen++;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        check_output("bubble_valid", 64'(out_valid), 64'd0);
        check_output("bubble_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int            beats;
        int            waited;
        logic [OW-1:0] first_idx;
        logic [OW-1:0] last_idx;
        logic [DW-1:0] rseq;
        int            mode;

        table_q[0] = '{32'h0000_0029, 8'h00, 0, 2,  6'd3,  18'h00600, 18'h00005};
        table_q[1] = '{32'h0000_0000, 8'h07, 0, 1,  6'd0,  18'h00000, 18'h00000};
        table_q[2] = '{32'hFFFF_FFFF, 8'hFF, 0, 16, 6'd32, 18'h200FF, 18'h23D1D};
        table_q[3] = '{32'h8000_0001, 8'h00, 5, 1,  6'd2,  18'h03E00, 18'h03E00};
        table_q[4] = '{32'h0000_0010, 8'h03, 0, 1,  6'd1,  18'h00007, 18'h00007};
        table_q[5] = '{32'h8000_0000, 8'hFF, 1, 1,  6'd1,  18'h0011E, 18'h0011E};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_seq    = '0;
        in_base   = '0;
        out_ready = 1'b0;
        #1;
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_idx", 64'(out_idx), 64'd0);
        check_output("rst_out_vld", 64'(out_lane_vld), 64'd0);
        check_output("rst_out_last", 64'(out_last), 64'd0);
        check_output("rst_out_count", 64'(out_count), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] table rows");
        for (int t = 0; t < 6; t++) begin
            apply_stimulus(table_q[t].seq, table_q[t].base, table_q[t].stall,
                           beats, first_idx, last_idx, waited);
            check_output("tbl_beats", 64'(beats), 64'(table_q[t].exp_beats));
            check_output("tbl_first_idx", 64'(first_idx), 64'(table_q[t].exp_first));
            check_output("tbl_last_idx", 64'(last_idx), 64'(table_q[t].exp_last));
            check_output("tbl_count_hold", 64'(out_count), 64'(table_q[t].exp_count));
        end

        $display("[TB] flush mid-row");
        in_valid = 1'b1;
        in_seq   = 32'h0000_00FF;
        in_base  = 8'h00;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("flush_beat2_idx", 64'(out_idx), 64'h602);
        flush = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check_output("flush_out_valid", 64'(out_valid), 64'd0);
        check_output("flush_in_ready", 64'(in_ready), 64'd1);
        check_output("flush_count", 64'(out_count), 64'd0);
        check_output("flush_vld", 64'(out_lane_vld), 64'd0);
        apply_stimulus(32'h0000_0010, 8'h00, 0, beats, first_idx, last_idx, waited);
        check_output("post_flush_idx", 64'(first_idx), 64'd4);

        $display("[TB] flush beats in_valid in idle");
        in_valid = 1'b1;
        in_seq   = 32'h0000_000F;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_output("flush_idle_valid", 64'(out_valid), 64'd0);
        check_output("flush_idle_ready", 64'(in_ready), 64'd1);

        $display("[TB] async reset mid-row");
        in_valid = 1'b1;
        in_seq   = 32'h0000_FFFF;
        in_base  = 8'h01;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_output("arst_in_ready", 64'(in_ready), 64'd1);
        check_output("arst_out_valid", 64'(out_valid), 64'd0);
        check_output("arst_out_idx", 64'(out_idx), 64'd0);
        check_output("arst_out_vld", 64'(out_lane_vld), 64'd0);
        check_output("arst_out_last", 64'(out_last), 64'd0);
        check_output("arst_out_count", 64'(out_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] back-to-back rows");
        apply_stimulus(32'h0000_0005, 8'h02, 0, beats, first_idx, last_idx, waited);
        check_output("b2b_row1_idx", 64'(first_idx), 64'((9'd4 << 9) | 9'd2));
        apply_stimulus(32'h0000_0003, 8'h04, 0, beats, first_idx, last_idx, waited);
        check_output("b2b_wait", 64'(waited), 64'd0);
        check_output("b2b_row2_idx", 64'(first_idx), 64'((9'd5 << 9) | 9'd4));

        $display("[TB] random rows");
        for (int r = 0; r < 80; r++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rseq = $urandom;
                1:       rseq = $urandom & $urandom & $urandom;
                2:       rseq = '0;
                default: rseq = ~($urandom & $urandom);
            endcase
            apply_stimulus(rseq, BW'($urandom), -1, beats, first_idx, last_idx, waited);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
